// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-bus bridge: command byte {rw, addr[6:0]} followed by a data burst.
// Optional macro SPI_REG_BRIDGE_AUTOINC_EN: reg_addr advances through a burst instead of holding.
module spi_reg_bridge #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  spi_ss,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [7:0]            reg_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_e;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            tx_q, tx_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  cap_q, cap_d;   // reg_rdata is valid this cycle; load it into tx
  logic                  got_q, got_d;   // at least one data byte accepted in this write frame
  logic                  err_q, err_d;

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= STATUS_BYTE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      got_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      got_q   <= got_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (spi_ss) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (rx_valid) state_d = rx_byte[7] ? WR_DATA : RD_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    cap_d   = rd_q & ~spi_ss;
    got_d   = got_q;
    err_d   = 1'b0;

    if (wr_q && AutoInc) addr_d = addr_q + ADDR_WIDTH'(1);
    if (cap_q) tx_d = reg_rdata;

    if (spi_ss) begin
      // Deselect drops anything not yet issued, including a pending tx reload.
      tx_d  = STATUS_BYTE;
      cap_d = 1'b0;
      got_d = 1'b0;
      err_d = (state_q == WR_DATA) && !got_q;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d  = STATUS_BYTE;
          got_d = 1'b0;
        end
        CMD: if (rx_valid) begin
          addr_d = rx_byte[ADDR_WIDTH-1:0];
          rd_d   = ~rx_byte[7];
        end
        WR_DATA: if (rx_valid) begin
          wdata_d = rx_byte;
          wr_d    = 1'b1;
          got_d   = 1'b1;
        end
        RD_DATA: if (rx_valid) begin
          rd_d = 1'b1;
          if (AutoInc) addr_d = addr_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    tx_byte   = tx_q;
    reg_addr  = addr_q;
    reg_wdata = wdata_q;
    reg_wr    = wr_q & ena;
    reg_rd    = rd_q & ena;
    frame_err = err_q & ena;
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge; expectations follow SPI_REG_BRIDGE_AUTOINC_EN when defined.
module tb_spi_reg_bridge;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       spi_ss = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .ena(ena), .spi_ss(spi_ss),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_byte(tx_byte),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register model: read data appears one clock after the read strobe.
  always @(posedge clk) if (reg_rd) reg_rdata <= {1'b0, reg_addr} ^ 8'hFF;

  logic [6:0] wr_addr_log [0:63];
  logic [7:0] wr_data_log [0:63];
  logic [6:0] rd_addr_log [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_wr && wr_cnt < 64) begin
      wr_addr_log[wr_cnt] = reg_addr;
      wr_data_log[wr_cnt] = reg_wdata;
    end
    if (reg_wr) wr_cnt++;
    if (reg_rd && rd_cnt < 64) rd_addr_log[rd_cnt] = reg_addr;
    if (reg_rd) rd_cnt++;
    if (frame_err) err_cnt++;
    if (reg_wr && reg_rd) both_seen = 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    cycles(4);
  endtask

  task automatic frame_start();
    @(negedge clk);
    spi_ss = 1'b0;
    cycles(2);
  endtask

  task automatic frame_end();
    @(negedge clk);
    spi_ss = 1'b1;
    cycles(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    checks++;
    if ({tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err} !== {8'hA5, 7'h00, 8'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state: tx=%h addr=%h wdata=%h wr=%b rd=%b busy=%b err=%b, required tx=a5 addr=00 wdata=00 all flags 0",
               tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err);
    end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_write_burst();
    int base = wr_cnt;
    int rbase = rd_cnt;
    logic [6:0] a1 = AUTOINC ? 7'h06 : 7'h05;
    frame_start();
    send_byte(8'h85);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_end();
    checks++;
    if (wr_cnt - base !== 2) begin
      failures++;
      $display("FAIL wr_burst_count: got %0d writes, required 2", wr_cnt - base);
    end else begin
      checks++;
      if ({wr_addr_log[base], wr_data_log[base]} !== {7'h05, 8'h11}) begin
        failures++;
        $display("FAIL wr_burst_first: addr=%h data=%h, required addr=05 data=11", wr_addr_log[base], wr_data_log[base]);
      end
      checks++;
      if ({wr_addr_log[base+1], wr_data_log[base+1]} !== {a1, 8'h22}) begin
        failures++;
        $display("FAIL wr_burst_second: addr=%h data=%h, required addr=%h data=22", wr_addr_log[base+1], wr_data_log[base+1], a1);
      end
    end
    checks++;
    if (rd_cnt !== rbase) begin
      failures++;
      $display("FAIL wr_burst_no_read: got %0d reads, required 0", rd_cnt - rbase);
    end
  endtask

  task automatic test_read();
    int rbase = rd_cnt;
    logic [6:0] a1 = AUTOINC ? 7'h11 : 7'h10;
    logic [7:0] t1 = AUTOINC ? 8'hEE : 8'hEF;
    frame_start();
    checks++;
    if (tx_byte !== 8'hA5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_cmd_status: tx=%h busy=%b, required tx=a5 busy=1", tx_byte, busy);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h10;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (reg_rd !== 1'b1 || reg_addr !== 7'h10) begin
      failures++;
      $display("FAIL rd_strobe_t1: rd=%b addr=%h, required rd=1 addr=10", reg_rd, reg_addr);
    end
    @(negedge clk);
    checks++;
    if (reg_rd !== 1'b0) begin
      failures++;
      $display("FAIL rd_strobe_width: rd=%b at T+2, required 0", reg_rd);
    end
    cycles(3);
    checks++;
    if (tx_byte !== 8'hEF) begin
      failures++;
      $display("FAIL rd_first_tx: tx=%h, required ef", tx_byte);
    end
    send_byte(8'h00);
    checks++;
    if (tx_byte !== t1 || rd_cnt - rbase !== 2 || rd_addr_log[rbase+1] !== a1) begin
      failures++;
      $display("FAIL rd_burst: tx=%h reads=%0d addr=%h, required tx=%h reads=2 addr=%h", tx_byte, rd_cnt - rbase, rd_addr_log[rbase+1], t1, a1);
    end
    frame_end();
    checks++;
    if (tx_byte !== 8'hA5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_frame_end: tx=%h busy=%b, required tx=a5 busy=0", tx_byte, busy);
    end
  endtask

  task automatic test_wrap();
    int base = wr_cnt;
    logic [6:0] a1 = AUTOINC ? 7'h00 : 7'h7F;
    frame_start();
    send_byte(8'hFF);
    send_byte(8'hAA);
    send_byte(8'hBB);
    frame_end();
    checks++;
    if (wr_cnt - base !== 2 || wr_addr_log[base] !== 7'h7F || wr_data_log[base] !== 8'hAA ||
        wr_addr_log[base+1] !== a1 || wr_data_log[base+1] !== 8'hBB) begin
      failures++;
      $display("FAIL wrap: writes=%0d a0=%h d0=%h a1=%h d1=%h, required writes=2 a0=7f d0=aa a1=%h d1=bb",
               wr_cnt - base, wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1], wr_data_log[base+1], a1);
    end
  endtask

  task automatic test_abort();
    int base = wr_cnt;
    int ebase = err_cnt;
    frame_start();
    send_byte(8'h81);
    send_byte(8'h33);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h44;
    spi_ss   = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    cycles(3);
    checks++;
    if (wr_cnt - base !== 1 || wr_data_log[base] !== 8'h33) begin
      failures++;
      $display("FAIL abort_writes: writes=%0d d0=%h, required writes=1 d0=33", wr_cnt - base, wr_data_log[base]);
    end
    checks++;
    if (busy !== 1'b0 || tx_byte !== 8'hA5 || err_cnt !== ebase) begin
      failures++;
      $display("FAIL abort_idle: busy=%b tx=%h err_pulses=%0d, required busy=0 tx=a5 err_pulses=0", busy, tx_byte, err_cnt - ebase);
    end
  endtask

  task automatic test_empty_write();
    int base = wr_cnt;
    int ebase = err_cnt;
    frame_start();
    send_byte(8'h83);
    frame_end();
    checks++;
    if (err_cnt - ebase !== 1 || wr_cnt !== base) begin
      failures++;
      $display("FAIL empty_write: err_cycles=%0d writes=%0d, required err_cycles=1 writes=0", err_cnt - ebase, wr_cnt - base);
    end
  endtask

  task automatic test_ena_hold();
    int base = wr_cnt;
    logic [6:0] exp_a [0:2];
    logic [7:0] exp_d [0:2];
    exp_a[0] = 7'h04;
    exp_a[1] = AUTOINC ? 7'h05 : 7'h04;
    exp_a[2] = AUTOINC ? 7'h06 : 7'h04;
    exp_d[0] = 8'h66;
    exp_d[1] = 8'h77;
    exp_d[2] = 8'h88;
    frame_start();
    send_byte(8'h84);
    @(negedge clk);
    ena      = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    cycles(3);
    checks++;
    if (wr_cnt !== base) begin
      failures++;
      $display("FAIL ena_ignored: writes=%0d, required 0", wr_cnt - base);
    end
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    frame_end();
    checks++;
    if (wr_cnt - base !== 3) begin
      failures++;
      $display("FAIL ena_burst_count: writes=%0d, required 3", wr_cnt - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_log[base+i] !== exp_a[i] || wr_data_log[base+i] !== exp_d[i]) begin
          failures++;
          $display("FAIL ena_burst_%0d: addr=%h data=%h, required addr=%h data=%h", i, wr_addr_log[base+i], wr_data_log[base+i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base = wr_cnt;
    frame_start();
    send_byte(8'h90);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || reg_addr !== 7'h00) begin
      failures++;
      $display("FAIL rst_mid_state: busy=%b addr=%h, required busy=0 addr=00", busy, reg_addr);
    end
    cycles(2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_reenter: busy=%b, required 1", busy);
    end
    send_byte(8'h92);
    send_byte(8'h34);
    frame_end();
    checks++;
    if (wr_cnt - base !== 1 || wr_addr_log[base] !== 7'h12 || wr_data_log[base] !== 8'h34) begin
      failures++;
      $display("FAIL rst_mid_newcmd: writes=%0d a0=%h d0=%h, required writes=1 a0=12 d0=34", wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
    end
  endtask

  task automatic test_exclusive_strobes();
    checks++;
    if (both_seen !== 1'b0) begin
      failures++;
      $display("FAIL strobe_exclusive: reg_wr and reg_rd seen high together");
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read();
    test_wrap();
    test_abort();
    test_empty_write();
    test_ena_hold();
    test_reset_midframe();
    test_exclusive_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
